// File: rtl/ks_prefix_pipe.sv
// ks_prefix_pipe: 4-stage pipelined 16-bit Kogge-Stone prefix network plus sum.
// R1 captures P/G/CIN with the carry-in folded into bit 0. R2 holds the result
// of prefix levels 1-2 (spans 1, 2). R3 holds the carries after levels 3-4
// (spans 4, 8). R4 holds the registered SUM/COUT.
// Each stage has its own valid bit, so empty slots collapse forward even while
// the output is stalled.
// Optional feature: define KS_OVF_EN to add the OVF port. OVF is signed
// overflow, computed as c15 ^ c16.
module ks_prefix_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] P_IN,
  input  logic [15:0] G_IN,
  input  logic        CIN,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] SUM,
  output logic        COUT,
`ifdef KS_OVF_EN
  output logic        OVF,
`endif
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int W      = 16;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [W-1:0] g;
    logic [W-1:0] p;
  } gp_t;

  // One prefix level: bit i >= span absorbs bit i-span; lower bits pass through.
  function automatic gp_t ks_level(input gp_t x, input int span);
    gp_t y;
    y = x;
    for (int i = span; i < W; i++) begin
      y.g[i] = x.g[i] | (x.p[i] & x.g[i-span]);
      y.p[i] = x.p[i] & x.p[i-span];
    end
    return y;
  endfunction

  // Final level only needs group generate (the carries); group propagate is dead.
  function automatic logic [W-1:0] ks_last(input gp_t x, input int span);
    logic [W-1:0] g;
    g = x.g;
    for (int i = span; i < W; i++) g[i] = x.g[i] | (x.p[i] & x.g[i-span]);
    return g;
  endfunction

  logic [STAGES:1] vld_pipe;
  wire  [STAGES:1] en;

  // Stage n may load when it or any stage after it has a hole, or the output drains.
  for (genvar n = 1; n <= STAGES; n++) begin : g_en
    assign en[n] = out_ready | ~(&vld_pipe[STAGES:n]);
  end

  assign in_ready  = en[1];
  assign out_valid = vld_pipe[STAGES];

  gp_t          r1_gp;   // r1_gp.p is still the original P here
  logic         r1_cin;
  gp_t          r2_gp;
  logic [W-1:0] r2_pin;
  logic         r2_cin;
  logic [W-1:0] r3_c;    // r3_c[i] == carry into bit i+1
  logic [W-1:0] r3_pin;
  logic         r3_cin;

  // Valid shift register; each stage advances only when its enable is up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else begin
      if (en[1]) vld_pipe[1] <= in_valid;
      for (int n = 2; n <= STAGES; n++)
        if (en[n]) vld_pipe[n] <= vld_pipe[n-1];
    end
  end

  // Datapath registers: capture, levels 1-2, levels 3-4, sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_gp  <= '0;
      r1_cin <= 1'b0;
      r2_gp  <= '0;
      r2_pin <= '0;
      r2_cin <= 1'b0;
      r3_c   <= '0;
      r3_pin <= '0;
      r3_cin <= 1'b0;
      SUM    <= '0;
      COUT   <= 1'b0;
    end else begin
      if (en[1]) begin
        r1_gp  <= {G_IN | {{(W-1){1'b0}}, P_IN[0] & CIN}, P_IN};
        r1_cin <= CIN;
      end
      if (en[2]) begin
        r2_gp  <= ks_level(ks_level(r1_gp, 1), 2);
        r2_pin <= r1_gp.p;
        r2_cin <= r1_cin;
      end
      if (en[3]) begin
        r3_c   <= ks_last(ks_level(r2_gp, 4), 8);
        r3_pin <= r2_pin;
        r3_cin <= r2_cin;
      end
      if (en[4]) begin
        SUM  <= r3_pin ^ {r3_c[W-2:0], r3_cin};
        COUT <= r3_c[W-1];
      end
    end
  end

`ifdef KS_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     OVF <= 1'b0;
    else if (en[4]) OVF <= r3_c[W-2] ^ r3_c[W-1];
  end
`endif

endmodule
